weight_ram_ctrl: RTL and testbench



---
 rtl/weight_ram_ctrl.sv | 140 ++++++++++++++
 tb/tb_weight_ram_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_ram_ctrl.sv
// weight_ram_ctrl: sequences the power-up/requested randomize pass of the
// N-wide weight RAM, then arbitrates forward-pass reads and weight-update
// writes onto the single RAM port.
module weight_ram_ctrl #(
  parameter int unsigned N     = 10,
  parameter int unsigned DW    = 10,
  parameter int unsigned AW    = 7,
  parameter int unsigned DEPTH = 65
) (
  input  logic            Clock,
  input  logic            Rst,
  input  logic            rand_req,
  output logic            init_done,
  output logic            busy,
  input  logic            rd_req,
  input  logic [AW-1:0]   rd_addr,
  output logic            rd_ack,
  output logic            rd_valid,
  input  logic            wr_req,
  input  logic [AW-1:0]   wr_addr,
  input  logic [N*DW-1:0] wr_data,
  output logic            wr_ack,
  output logic            err,
  output logic            ram_in,
  output logic            ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [N*DW-1:0] ram_d
);

  localparam int unsigned INIT_LEN = DEPTH + 1;
  localparam int unsigned CW       = $clog2(INIT_LEN + 1);
  localparam int unsigned MAX_BASE = DEPTH - N;

  typedef enum logic [1:0] {INIT, IDLE, ACCESS, RD_WAIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_wr;
  logic          op_wr;
  logic          op_bad;

  logic          grant_rd_c;
  logic          grant_wr_c;
  logic [AW-1:0] gnt_addr_c;
  logic          gnt_bad_c;

  // Round-robin pick between the requesters; a lone requester always wins
  always_comb begin
    grant_rd_c = 1'b0;
    grant_wr_c = 1'b0;
    if (rd_req && wr_req) begin
      grant_rd_c = last_wr;
      grant_wr_c = !last_wr;
    end else begin
      grant_rd_c = rd_req;
      grant_wr_c = wr_req;
    end
    gnt_addr_c = grant_wr_c ? wr_addr : rd_addr;
    gnt_bad_c  = 32'(gnt_addr_c) > MAX_BASE;
  end

  // Controller FSM; pulses default low each cycle, RAM address/data hold
  always_ff @(posedge Clock) begin
    if (Rst) begin
      state     <= INIT;
      cnt       <= '0;
      last_wr   <= 1'b1;
      op_wr     <= 1'b0;
      op_bad    <= 1'b0;
      init_done <= 1'b0;
      busy      <= 1'b0;
      rd_ack    <= 1'b0;
      wr_ack    <= 1'b0;
      rd_valid  <= 1'b0;
      err       <= 1'b0;
      ram_in    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_d     <= '0;
    end else begin
      rd_ack   <= 1'b0;
      wr_ack   <= 1'b0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
      ram_we   <= 1'b0;
      unique case (state)
        INIT: begin
          // One extra cycle past DEPTH lets the RAM's fill counter wrap to 0
          if (cnt == CW'(INIT_LEN)) begin
            ram_in    <= 1'b0;
            init_done <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            ram_in <= 1'b1;
            busy   <= 1'b1;
            cnt    <= cnt + CW'(1);
          end
        end
        IDLE: begin
          if (rand_req) begin
            state     <= INIT;
            init_done <= 1'b0;
            busy      <= 1'b1;
            cnt       <= '0;
          end else if (grant_rd_c || grant_wr_c) begin
            state    <= ACCESS;
            busy     <= 1'b1;
            last_wr  <= grant_wr_c;
            op_wr    <= grant_wr_c;
            op_bad   <= gnt_bad_c;
            ram_addr <= gnt_addr_c;
            ram_we   <= grant_wr_c && !gnt_bad_c;
            if (grant_wr_c) begin
              ram_d <= wr_data;
            end
            rd_ack <= grant_rd_c;
            wr_ack <= grant_wr_c;
            err    <= gnt_bad_c;
          end
        end
        ACCESS: begin
          if (!op_wr && !op_bad) begin
            state    <= RD_WAIT;
            rd_valid <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RD_WAIT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_ram_ctrl.sv
// Bench for weight_ram_ctrl: directed vector table plus hand sequences for
// contention, re-randomize and mid-access reset, then random traffic checked
// cycle by cycle against a schedule-based reference model.
module tb_weight_ram_ctrl;

  localparam int unsigned N        = 10;
  localparam int unsigned DW       = 10;
  localparam int unsigned AW       = 7;
  localparam int unsigned DEPTH    = 65;
  localparam int          INIT_LEN = DEPTH + 1;
  localparam int          MAX_BASE = DEPTH - N;
  localparam int          MAXC     = 8192;

  logic            Clock = 1'b0;
  logic            Rst = 1'b1;
  logic            rand_req = 1'b0;
  logic            rd_req = 1'b0;
  logic            wr_req = 1'b0;
  logic [AW-1:0]   rd_addr = '0;
  logic [AW-1:0]   wr_addr = '0;
  logic [N*DW-1:0] wr_data = '0;
  logic            init_done, busy, rd_ack, rd_valid, wr_ack, err, ram_in, ram_we;
  logic [AW-1:0]   ram_addr;
  logic [N*DW-1:0] ram_d;

  weight_ram_ctrl #(.N(N), .DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .Clock(Clock), .Rst(Rst), .rand_req(rand_req), .init_done(init_done), .busy(busy),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .err(err),
    .ram_in(ram_in), .ram_we(ram_we), .ram_addr(ram_addr), .ram_d(ram_d)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
  endtask

  task automatic check_d(input string name, input logic [N*DW-1:0] got, input logic [N*DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
  endtask

  // ---------------- reference model: per-cycle expected timeline ----------------
  typedef struct packed {
    bit ram_in; bit busy; bit rd_ack; bit wr_ack; bit rd_valid; bit err; bit ram_we;
  } flags_t;

  flags_t          e_fl [MAXC];
  bit              e_set[MAXC];
  logic [AW-1:0]   e_av [MAXC];
  bit              e_dset[MAXC];
  logic [N*DW-1:0] e_dv [MAXC];
  int              ready_at   = 0;
  int              idone_from = 0;
  int              armed_from = -1;
  bit              m_last_wr  = 1'b1;
  logic [AW-1:0]   exp_addr   = '0;
  logic [N*DW-1:0] exp_d      = '0;
  bit              m_w;
  bit              m_bad;
  logic [AW-1:0]   m_a;
  logic [7:0]      got_fl;
  logic [7:0]      exp_fl;
  int              k;

  // Randomize pass: 66 cycles of ram_in starting two cycles after cycle k
  task automatic start_init(input int kk, input bit via_rand);
    for (int c = kk + 1; c < kk + 80 && c < MAXC; c++) begin
      e_fl[c] = '0; e_set[c] = 1'b0; e_dset[c] = 1'b0;
    end
    if (via_rand) e_fl[kk+1].busy = 1'b1;
    for (int c = kk + 2; c <= kk + 1 + INIT_LEN && c < MAXC; c++) begin
      e_fl[c].ram_in = 1'b1;
      e_fl[c].busy   = 1'b1;
    end
    idone_from = kk + 2 + INIT_LEN;
    ready_at   = kk + 2 + INIT_LEN;
  endtask

  always @(negedge Clock) begin
    k = cyc;
    if (armed_from >= 0 && k >= armed_from && k < MAXC) begin
      if (e_set[k])  exp_addr = e_av[k];
      if (e_dset[k]) exp_d    = e_dv[k];
      got_fl = {ram_in, init_done, busy, rd_ack, wr_ack, rd_valid, err, ram_we};
      exp_fl = {e_fl[k].ram_in, (k >= idone_from), e_fl[k].busy, e_fl[k].rd_ack,
                e_fl[k].wr_ack, e_fl[k].rd_valid, e_fl[k].err, e_fl[k].ram_we};
      check("model_flags", 64'(got_fl), 64'(exp_fl));
      check("model_ram_addr", 64'(ram_addr), 64'(exp_addr));
      check_d("model_ram_d", ram_d, exp_d);
    end
    if (k + 3 < MAXC - 80) begin
      if (Rst) begin
        start_init(k, 1'b0);
        e_set[k+1] = 1'b1; e_av[k+1] = '0;
        e_dset[k+1] = 1'b1; e_dv[k+1] = '0;
        m_last_wr = 1'b1;
        if (armed_from < 0) armed_from = k + 1;
      end else if (armed_from >= 0 && k >= ready_at) begin
        if (rand_req) begin
          start_init(k, 1'b1);
        end else if (rd_req || wr_req) begin
          m_w   = (rd_req && wr_req) ? !m_last_wr : wr_req;
          m_a   = m_w ? wr_addr : rd_addr;
          m_bad = int'(m_a) > MAX_BASE;
          m_last_wr = m_w;
          e_fl[k+1].busy   = 1'b1;
          e_fl[k+1].wr_ack = m_w;
          e_fl[k+1].rd_ack = !m_w;
          e_fl[k+1].err    = m_bad;
          e_fl[k+1].ram_we = m_w && !m_bad;
          e_set[k+1] = 1'b1; e_av[k+1] = m_a;
          if (m_w) begin e_dset[k+1] = 1'b1; e_dv[k+1] = wr_data; end
          if (!m_w && !m_bad) begin
            e_fl[k+2].busy     = 1'b1;
            e_fl[k+2].rd_valid = 1'b1;
            ready_at = k + 3;
          end else begin
            ready_at = k + 2;
          end
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_idle();
    int c;
    c = 0;
    @(negedge Clock);
    while (!(init_done && !busy) && c < 300) begin
      @(negedge Clock);
      c++;
    end
    check("idle_reached", 64'(init_done && !busy), 64'(1));
  endtask

  task automatic count_init(output int n);
    n = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge Clock);
      if (init_done) break;
      if (ram_in) n++;
    end
  endtask

  task automatic run_req(input logic w, input logic [AW-1:0] a, input logic [N*DW-1:0] d,
                         output logic ack, output logic e, output logic we, output logic v);
    wait_idle();
    @(posedge Clock); #1;
    if (w) begin wr_req = 1'b1; wr_addr = a; wr_data = d; end
    else begin rd_req = 1'b1; rd_addr = a; end
    @(posedge Clock); #1;
    @(negedge Clock);
    ack = w ? wr_ack : rd_ack;
    e   = err;
    we  = ram_we;
    @(posedge Clock); #1;
    rd_req = 1'b0; wr_req = 1'b0;
    @(negedge Clock);
    v = rd_valid;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(99) < 80) return AW'($urandom_range(60));
    return AW'($urandom_range(127));
  endfunction

  typedef struct packed {
    logic w; logic [AW-1:0] a; logic e_err; logic e_valid; logic e_we;
  } vec_t;

  vec_t            tbl[10];
  logic [N*DW-1:0] dv;
  logic            g_ack, g_err, g_we, g_v;
  int              n;
  int              seq[4];
  int              ns;
  bit              got;
  logic            idone_at;
  bit              s_rd, s_wr;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 7'd10,  1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 7'd10,  1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 7'd56,  1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 7'd55,  1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 7'd127, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 7'd55,  1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 7'd0,   1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 7'd56,  1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 7'd0,   1'b0, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 7'd20,  1'b0, 1'b0, 1'b1};

    // Reset state and power-up randomize pass
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("reset_outputs", 64'({init_done, busy, rd_ack, rd_valid, wr_ack, err, ram_in, ram_we}), 64'(0));
    @(posedge Clock); #1;
    Rst = 1'b0;
    count_init(n);
    check("init_len", 64'(n), 64'(INIT_LEN));
    check("init_done_set", 64'(init_done), 64'(1));
    check("busy_after_init", 64'(busy), 64'(0));

    // Single-request vector table
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < int'(N); j++) dv[j*DW +: DW] = DW'(j + 1 + 16 * i);
      run_req(tbl[i].w, tbl[i].a, dv, g_ack, g_err, g_we, g_v);
      check($sformatf("vec%0d_ack", i), 64'(g_ack), 64'(1));
      check($sformatf("vec%0d_err", i), 64'(g_err), 64'(tbl[i].e_err));
      check($sformatf("vec%0d_we", i), 64'(g_we), 64'(tbl[i].e_we));
      check($sformatf("vec%0d_valid", i), 64'(g_v), 64'(tbl[i].e_valid));
    end

    // Contention with both requests held: grants alternate, read first
    wait_idle();
    @(posedge Clock); #1;
    rd_req = 1'b1; rd_addr = 7'd5;
    wr_req = 1'b1; wr_addr = 7'd6; wr_data = (N*DW)'(128'h1234_5678);
    for (int i = 0; i < 4; i++) seq[i] = -1;
    ns = 0;
    for (int c = 0; c < 40 && ns < 4; c++) begin
      @(negedge Clock);
      if (rd_ack) begin seq[ns] = 0; ns++; end
      else if (wr_ack) begin seq[ns] = 1; ns++; end
    end
    @(posedge Clock); #1;
    rd_req = 1'b0; wr_req = 1'b0;
    check("arb_grant_count", 64'(ns), 64'(4));
    for (int i = 0; i < 4; i++) check($sformatf("arb_grant%0d", i), 64'(seq[i]), 64'(i % 2));

    // Re-randomize with a read pending: read waits for the whole pass
    wait_idle();
    @(posedge Clock); #1;
    rand_req = 1'b1; rd_req = 1'b1; rd_addr = 7'd3;
    @(posedge Clock); #1;
    rand_req = 1'b0;
    n = 0; got = 1'b0; idone_at = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge Clock);
      if (rd_ack) begin got = 1'b1; idone_at = init_done; break; end
      if (ram_in) n++;
    end
    @(posedge Clock); #1;
    rd_req = 1'b0;
    check("rand_ack_seen", 64'(got), 64'(1));
    check("rand_init_len", 64'(n), 64'(INIT_LEN));
    check("rand_ack_after_init", 64'(idone_at), 64'(1));

    // Reset during a read's ACCESS cycle: no rd_valid, full INIT restarts
    wait_idle();
    @(posedge Clock); #1;
    rd_req = 1'b1; rd_addr = 7'd7;
    @(posedge Clock); #1;
    Rst = 1'b1;
    @(negedge Clock);
    check("rst_access_ack", 64'(rd_ack), 64'(1));
    @(posedge Clock); #1;
    Rst = 1'b0; rd_req = 1'b0;
    @(negedge Clock);
    check("rst_outputs_zero", 64'({rd_valid, rd_ack, busy, init_done, ram_in, err}), 64'(0));
    count_init(n);
    check("rst_init_len", 64'(n), 64'(INIT_LEN));

    // Random traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clock);
      s_rd = rd_ack; s_wr = wr_ack;
      @(posedge Clock); #1;
      Rst      = ($urandom_range(599) == 0);
      rand_req = !Rst && ($urandom_range(249) == 0);
      if (rd_req) begin
        if (s_rd && $urandom_range(1) == 0) rd_req = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        rd_req = 1'b1; rd_addr = rnd_addr();
      end
      if (wr_req) begin
        if (s_wr && $urandom_range(1) == 0) wr_req = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        wr_req  = 1'b1; wr_addr = rnd_addr();
        wr_data = (N*DW)'({$urandom(), $urandom(), $urandom(), $urandom()});
      end
    end
    @(posedge Clock); #1;
    Rst = 1'b0; rand_req = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    repeat (80) @(posedge Clock);
    @(negedge Clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
